// File: rtl/security_pkg.sv
// -----------------------------------------------------------------------------
// security_pkg
// Shared definitions for the home-security blocks: core command encodings,
// keypad arbiter state encodings, the default flush digit and a helper that
// decides whether a keypad command is acceptable in the core's current mode.
// -----------------------------------------------------------------------------
package security_pkg;

   localparam logic [1:0] COM_NONE = 2'd0;
   localparam logic [1:0] COM_ARM  = 2'd1;
   localparam logic [1:0] COM_DIS  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_SESSION = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   localparam logic [3:0] FILL_DIGIT_DEFAULT = 4'hF;

   // Arming only makes sense when disarmed; disarming when armed or alarming.
   // The reserved encoding never qualifies.
   function automatic logic cmd_eligible(input logic [1:0] cmd,
                                         input logic       armed,
                                         input logic       alarm);
      return ((cmd == COM_ARM) && !armed) ||
             ((cmd == COM_DIS) && (armed || alarm));
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the eligible mask upward from
// the pointer, wrapping past the top, and returns the first hit as one-hot.
//   eligible : N-bit request mask
//   pointer  : index that has highest priority this round
//   winner   : one-hot winner, all zero when nothing is eligible
//   valid    : at least one request is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [PW-1:0] pointer,
   output logic [N-1:0]  winner,
   output logic          valid
);

   function automatic logic [PW-1:0] wrap_idx(input int v);
      return PW'(v % N);
   endfunction

   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no path leaves it unassigned (which would infer a latch).
   always_comb begin
      winner = '0;
      // Walk offsets from farthest to nearest; the nearest hit overwrites
      // any earlier one, so the lowest offset from the pointer wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[wrap_idx(int'(pointer) + i)]) begin
            winner                               = '0;
            winner[wrap_idx(int'(pointer) + i)] = 1'b1;
         end
      end
   end

   assign valid = |eligible;

endmodule

// File: rtl/keypad_arbiter.sv
// -----------------------------------------------------------------------------
// keypad_arbiter
// Shares one security core between N_PADS keypads. A round-robin winner gets
// an exclusive session: its command goes to the core for one cycle, then
// exactly CODE_LEN of its digits are forwarded. If the owner goes quiet for
// TIMEOUT cycles the remaining digits are filled with FILL_DIGIT so the core
// never waits on a half-entered code.
//   clk, reset         : clock, synchronous active-high reset
//   pad_command        : 2 bits per pad (0 none, 1 arm, 2 disarm, 3 reserved)
//   pad_digit          : 4 bits per pad
//   pad_digit_valid    : one strobe per pad
//   core_armed/alarm   : core status used to qualify requests
//   core_command       : command to the core, high only during CMD
//   core_digit/_enterd : digit and strobe to the core
//   grant              : one-hot session owner, 0 when idle or releasing
//   busy               : any state other than IDLE
//   timeout_flush      : one-cycle pulse as a flush begins
// -----------------------------------------------------------------------------
module keypad_arbiter
   import security_pkg::*;
#(
   parameter int         N_PADS     = 4,
   parameter int         CODE_LEN   = 3,
   parameter int         TIMEOUT    = 255,
   parameter logic [3:0] FILL_DIGIT = FILL_DIGIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2*N_PADS-1:0]   pad_command,
   input  logic [4*N_PADS-1:0]   pad_digit,
   input  logic [N_PADS-1:0]     pad_digit_valid,
   input  logic                  core_armed,
   input  logic                  core_alarm,
   output logic [1:0]            core_command,
   output logic [3:0]            core_digit,
   output logic                  core_digit_enterd,
   output logic [N_PADS-1:0]     grant,
   output logic                  busy,
   output logic                  timeout_flush
);

   localparam int PW  = $clog2(N_PADS);
   localparam int DCW = $clog2(CODE_LEN + 1);
   localparam int ICW = $clog2(TIMEOUT + 1);

   localparam logic [DCW-1:0] CODE_LAST  = DCW'(CODE_LEN);
   localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT);
   localparam logic [PW-1:0]  LAST_PAD   = PW'(N_PADS - 1);

   state_t          state;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   pointer;
   logic [DCW-1:0]  digit_cnt;
   logic [ICW-1:0]  idle_cnt;

   logic [N_PADS-1:0] eligible;
   logic [N_PADS-1:0] winner;
   logic              win_valid;
   logic [PW-1:0]     win_idx;
   logic              owner_valid;
   logic [3:0]        owner_digit;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_PADS; i++) begin
         eligible[i] = cmd_eligible(pad_command[2*i +: 2], core_armed, core_alarm);
      end
   end

   rr_pick #(
      .N  (N_PADS),
      .PW (PW)
   ) u_pick (
      .eligible (eligible),
      .pointer  (pointer),
      .winner   (winner),
      .valid    (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_PADS; i++) begin
         if (winner[i]) win_idx = PW'(i);
      end
   end

   assign owner_valid = pad_digit_valid[owner];
   assign owner_digit = pad_digit[{owner, 2'b00} +: 4];
   assign busy        = (state != ST_IDLE);

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         owner             <= '0;
         pointer           <= '0;
         digit_cnt         <= '0;
         idle_cnt          <= '0;
         core_command      <= COM_NONE;
         core_digit        <= '0;
         core_digit_enterd <= 1'b0;
         grant             <= '0;
         timeout_flush     <= 1'b0;
      end else begin
         // Single-cycle outputs fall back to idle unless a state drives them.
         core_command      <= COM_NONE;
         core_digit_enterd <= 1'b0;
         timeout_flush     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  owner        <= win_idx;
                  grant        <= winner;
                  core_command <= pad_command[{win_idx, 1'b0} +: 2];
                  state        <= ST_CMD;
               end
            end

            ST_CMD: begin
               digit_cnt <= '0;
               idle_cnt  <= '0;
               state     <= ST_SESSION;
            end

            ST_SESSION: begin
               // Leave one cycle after the last digit so its strobe is seen
               // while still in SESSION, never in RELEASE.
               if (digit_cnt == CODE_LAST) begin
                  grant <= '0;
                  state <= ST_RELEASE;
               end else if (owner_valid) begin
                  // An owner digit beats a timeout landing on the same cycle.
                  core_digit        <= owner_digit;
                  core_digit_enterd <= 1'b1;
                  digit_cnt         <= digit_cnt + DCW'(1);
                  idle_cnt          <= '0;
               end else if (idle_cnt + ICW'(1) == IDLE_LIMIT) begin
                  idle_cnt      <= IDLE_LIMIT;
                  timeout_flush <= 1'b1;
                  state         <= ST_FLUSH;
               end else begin
                  idle_cnt <= idle_cnt + ICW'(1);
               end
            end

            ST_FLUSH: begin
               if (digit_cnt != CODE_LAST) begin
                  core_digit        <= FILL_DIGIT;
                  core_digit_enterd <= 1'b1;
                  digit_cnt         <= digit_cnt + DCW'(1);
               end else begin
                  grant <= '0;
                  state <= ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               // Start the next search just past the released pad.
               pointer <= (owner == LAST_PAD) ? '0 : owner + PW'(1);
               state   <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_arbiter.sv
// -----------------------------------------------------------------------------
// tb_keypad_arbiter
// Self-checking bench for keypad_arbiter (4 pads, 3-digit codes, TIMEOUT 8).
// A per-cycle vector table covers a full arm session and request
// qualification; hand-written sequences cover fairness, foreign digits,
// timeout flush, digit-beats-timeout and reset mid-session. Forwarded digits
// are predicted into a queue when driven and popped when the core strobe
// appears.
// -----------------------------------------------------------------------------
module tb_keypad_arbiter;

   localparam int N_PADS   = 4;
   localparam int CODE_LEN = 3;
   localparam int TIMEOUT  = 8;
   localparam logic [3:0] FILL = 4'hF;

   logic                clk = 1'b0;
   logic                reset;
   logic [2*N_PADS-1:0] pad_command;
   logic [4*N_PADS-1:0] pad_digit;
   logic [N_PADS-1:0]   pad_digit_valid;
   logic                core_armed;
   logic                core_alarm;
   logic [1:0]          core_command;
   logic [3:0]          core_digit;
   logic                core_digit_enterd;
   logic [N_PADS-1:0]   grant;
   logic                busy;
   logic                timeout_flush;

   keypad_arbiter #(
      .N_PADS     (N_PADS),
      .CODE_LEN   (CODE_LEN),
      .TIMEOUT    (TIMEOUT),
      .FILL_DIGIT (FILL)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pad_command       (pad_command),
      .pad_digit         (pad_digit),
      .pad_digit_valid   (pad_digit_valid),
      .core_armed        (core_armed),
      .core_alarm        (core_alarm),
      .core_command      (core_command),
      .core_digit        (core_digit),
      .core_digit_enterd (core_digit_enterd),
      .grant             (grant),
      .busy              (busy),
      .timeout_flush     (timeout_flush)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   logic [3:0] sb[$];

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] dig;
      logic [3:0]  dv;
      logic        armed;
      logic        alarm;
      logic        push;
      logic [3:0]  pdig;
      logic [1:0]  e_cmd;
      logic [3:0]  e_grant;
      logic        e_busy;
      logic        e_en;
      logic        e_tf;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl[NV];

   function automatic vec_t mk(logic [7:0] cmd, logic [15:0] dig, logic [3:0] dv,
                               logic armed, logic alarm, logic push, logic [3:0] pdig,
                               logic [1:0] e_cmd, logic [3:0] e_grant, logic e_busy,
                               logic e_en, logic e_tf);
      vec_t v;
      v.cmd = cmd; v.dig = dig; v.dv = dv; v.armed = armed; v.alarm = alarm;
      v.push = push; v.pdig = pdig; v.e_cmd = e_cmd; v.e_grant = e_grant;
      v.e_busy = e_busy; v.e_en = e_en; v.e_tf = e_tf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample #1 after the edge and retire any strobed digit
   // against the prediction queue.
   task automatic step();
      logic [3:0] exp;
      @(posedge clk);
      #1;
      if (core_digit_enterd === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_strobe", 32'(core_digit_enterd), 32'd0);
         end else begin
            exp = sb.pop_front();
            check("core_digit", 32'(core_digit), 32'(exp));
         end
      end
   endtask

   task automatic drive(input logic [7:0] cmd, input logic [15:0] dig, input logic [3:0] dv,
                        input logic armed, input logic alarm);
      pad_command     = cmd;
      pad_digit       = dig;
      pad_digit_valid = dv;
      core_armed      = armed;
      core_alarm      = alarm;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_cmd"},   32'(core_command),      32'd0);
      check({tag, "_digit"}, 32'(core_digit),        32'd0);
      check({tag, "_en"},    32'(core_digit_enterd), 32'd0);
      check({tag, "_grant"}, 32'(grant),             32'd0);
      check({tag, "_busy"},  32'(busy),              32'd0);
      check({tag, "_tf"},    32'(timeout_flush),     32'd0);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      drive(8'h00, 16'h0000, 4'h0, 1'b0, 1'b0);
      step();
      check_quiet(tag);
      reset = 1'b0;
   endtask

   initial begin
      // Arm session on pad1 with digits 4,2,1 every third cycle.
      tbl[0]  = mk(8'h04, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd1, 4'b0010, 1, 0, 0);
      tbl[1]  = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0010, 1, 0, 0);
      tbl[2]  = mk(8'h00, 16'h0040, 4'h2, 0, 0, 1, 4'h4, 2'd0, 4'b0010, 1, 1, 0);
      tbl[3]  = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0010, 1, 0, 0);
      tbl[4]  = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0010, 1, 0, 0);
      tbl[5]  = mk(8'h00, 16'h0020, 4'h2, 0, 0, 1, 4'h2, 2'd0, 4'b0010, 1, 1, 0);
      tbl[6]  = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0010, 1, 0, 0);
      tbl[7]  = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0010, 1, 0, 0);
      tbl[8]  = mk(8'h00, 16'h0010, 4'h2, 0, 0, 1, 4'h1, 2'd0, 4'b0010, 1, 1, 0);
      tbl[9]  = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 1, 0, 0);
      tbl[10] = mk(8'h00, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 0, 0, 0);
      // Request qualification: disarm while disarmed, reserved, arm while armed.
      tbl[11] = mk(8'h80, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 0, 0, 0);
      tbl[12] = mk(8'hC0, 16'h0000, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 0, 0, 0);
      tbl[13] = mk(8'h01, 16'h0000, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 0, 0, 0);
      tbl[14] = mk(8'h80, 16'h0000, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 0, 0, 0);
      // Disarm qualifies while alarming.
      tbl[15] = mk(8'h80, 16'h0000, 4'h0, 0, 1, 0, 4'h0, 2'd2, 4'b1000, 1, 0, 0);

      do_reset("reset0");
      step();
      check_quiet("reset0_hold");

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].cmd, tbl[i].dig, tbl[i].dv, tbl[i].armed, tbl[i].alarm);
         if (tbl[i].push) sb.push_back(tbl[i].pdig);
         step();
         check($sformatf("v%0d_cmd", i),   32'(core_command),      32'(tbl[i].e_cmd));
         check($sformatf("v%0d_grant", i), 32'(grant),             32'(tbl[i].e_grant));
         check($sformatf("v%0d_busy", i),  32'(busy),              32'(tbl[i].e_busy));
         check($sformatf("v%0d_en", i),    32'(core_digit_enterd), 32'(tbl[i].e_en));
         check($sformatf("v%0d_tf", i),    32'(timeout_flush),     32'(tbl[i].e_tf));
      end

      // Reset during CMD, pointer back to 0.
      do_reset("reset1");

      // Pads 0 and 2 request together; pad0 first, foreign digits ignored.
      drive(8'h11, 16'h0000, 4'h0, 0, 0);
      step();
      check("rr_first_grant", 32'(grant), 32'h1);
      check("rr_first_cmd", 32'(core_command), 32'd1);
      step();
      check("rr_session_grant", 32'(grant), 32'h1);
      drive(8'h11, 16'h0007, 4'h1, 0, 0); sb.push_back(4'h7); step();
      drive(8'h11, 16'h0900, 4'h4, 0, 0); step();
      check("foreign_digit_en", 32'(core_digit_enterd), 32'd0);
      drive(8'h11, 16'h0008, 4'h1, 0, 0); sb.push_back(4'h8); step();
      drive(8'h11, 16'h0309, 4'h5, 0, 0); sb.push_back(4'h9); step();
      check("third_digit_busy", 32'(busy), 32'd1);
      drive(8'h11, 16'h0000, 4'h0, 0, 0);
      step();
      check("release_grant", 32'(grant), 32'h0);
      check("release_busy", 32'(busy), 32'd1);
      step();
      check("idle_gap_busy", 32'(busy), 32'd0);
      step();
      check("rr_second_grant", 32'(grant), 32'h4);
      check("rr_second_cmd", 32'(core_command), 32'd1);

      // Pad2 enters one digit then goes silent: flush after TIMEOUT cycles.
      drive(8'h00, 16'h0000, 4'h0, 0, 0);
      step();
      drive(8'h00, 16'h0500, 4'h4, 0, 0); sb.push_back(4'h5); step();
      drive(8'h00, 16'h0000, 4'h0, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step();
         check($sformatf("pre_timeout_tf%0d", i), 32'(timeout_flush), 32'd0);
      end
      step();
      check("timeout_pulse", 32'(timeout_flush), 32'd1);
      check("timeout_en", 32'(core_digit_enterd), 32'd0);
      sb.push_back(FILL); sb.push_back(FILL);
      step();
      check("flush1_en", 32'(core_digit_enterd), 32'd1);
      check("flush1_tf", 32'(timeout_flush), 32'd0);
      step();
      check("flush2_en", 32'(core_digit_enterd), 32'd1);
      step();
      check("flush_release_grant", 32'(grant), 32'h0);
      check("flush_release_en", 32'(core_digit_enterd), 32'd0);
      step();
      check("flush_idle_busy", 32'(busy), 32'd0);

      // Pad3: a digit on the would-be timeout cycle wins, then reset mid-session.
      drive(8'h40, 16'h0000, 4'h0, 0, 0);
      step();
      check("pad3_grant", 32'(grant), 32'h8);
      drive(8'h00, 16'h0000, 4'h0, 0, 0);
      step();
      drive(8'h00, 16'h6000, 4'h8, 0, 0); sb.push_back(4'h6); step();
      drive(8'h00, 16'h0000, 4'h0, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      drive(8'h00, 16'h2000, 4'h8, 0, 0); sb.push_back(4'h2); step();
      check("digit_wins_tf", 32'(timeout_flush), 32'd0);
      check("digit_wins_en", 32'(core_digit_enterd), 32'd1);
      drive(8'h00, 16'h0000, 4'h0, 0, 0);
      step();
      check("digit_wins_busy", 32'(busy), 32'd1);
      check("digit_wins_tf2", 32'(timeout_flush), 32'd0);
      do_reset("reset_mid");
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("post_reset_en%0d", i), 32'(core_digit_enterd), 32'd0);
         check($sformatf("post_reset_busy%0d", i), 32'(busy), 32'd0);
      end

      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/keypad_arbiter.md
Name: keypad_arbiter

Overview:
- Shares the single home-security core between N_PADS keypads.
- Grants one keypad an exclusive session, forwards its arm/disarm command and exactly CODE_LEN digits to the core, then releases.
- Guarantees the core never stalls mid-code: an abandoned session is auto-flushed with filler digits after an inactivity timeout.
- Sits between the keypad front-ends and the security core's command/digit/digit_enterd inputs.

Parameters:
- N_PADS, 4, number of keypads (2..8)
- CODE_LEN, 3, digits per code sequence expected by the core
- TIMEOUT, 255, idle cycles in SESSION before a flush starts (1..65535)
- FILL_DIGIT, 4'hF, digit value injected during a flush

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pad_command  in  2*N_PADS  per-pad command; 0 none, 1 arm, 2 disarm, 3 reserved (ignored)
- pad_digit  in  4*N_PADS  per-pad digit value
- pad_digit_valid  in  N_PADS  per-pad one-cycle digit strobe
- core_armed  in  1  armed flag from the core
- core_alarm  in  1  alarm flag from the core
- core_command  out  2  command to the core (registered)
- core_digit  out  4  digit to the core (registered)
- core_digit_enterd  out  1  digit strobe to the core (registered)
- grant  out  N_PADS  one-hot owner of the current session; 0 when idle
- busy  out  1  high in any state other than IDLE
- timeout_flush  out  1  one-cycle pulse when a flush begins

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; counters 0.
- Reset mid-session: abandons the session immediately; no flush is emitted.
- States: IDLE, CMD, SESSION, FLUSH, RELEASE.
- Request eligibility:
  - pad i is eligible when pad_command[i]==1 and core_armed==0, or pad_command[i]==2 and (core_armed|core_alarm)==1.
  - Ineligible and reserved requests are silently ignored.
- IDLE:
  - Round-robin among eligible pads, starting at the pointer and searching upward with wrap-around.
  - On a winner: latch its index and command, set grant, go to CMD.
  - Pad digits in IDLE are dropped.
- CMD (1 cycle):
  - core_command = latched command for exactly this cycle; 0 in every other state.
  - Clear the digit counter and idle counter; go to SESSION.
- SESSION:
  - On the owner's pad_digit_valid: the next cycle drives core_digit_enterd=1 and core_digit=pad_digit (1-cycle latency).
  - Increment the digit counter and clear the idle counter.
  - When the counter reaches CODE_LEN, go to RELEASE.
  - Non-owner digits and all commands are ignored.
  - With no owner digit, the idle counter increments.
  - When the idle counter reaches TIMEOUT: pulse timeout_flush, go to FLUSH.
  - An owner digit in the same cycle the idle counter would reach TIMEOUT wins: the digit is forwarded and no flush starts.
- FLUSH:
  - Emit FILL_DIGIT with core_digit_enterd=1 on consecutive cycles, (CODE_LEN - count) times, then go to RELEASE.
  - All pad inputs are ignored.
- RELEASE (1 cycle):
  - grant=0; pointer = owner index + 1 modulo N_PADS; go to IDLE.
  - The released pad cannot win again ahead of waiting pads.
- grant is valid from CMD through RELEASE exclusive; busy = (state != IDLE).
- core_digit_enterd is never high in IDLE, CMD or RELEASE.
- Counter widths: digit counter clog2(CODE_LEN+1); idle counter clog2(TIMEOUT+1); no wrap, saturates at its limit.

Decomposition:
- Shared package `security_pkg` holds:
  - command encodings: COM_NONE=0, COM_ARM=1, COM_DIS=2
  - state encodings for IDLE, CMD, SESSION, FLUSH, RELEASE
  - FILL_DIGIT default
- One sub-module, `rr_pick`:
  - combinational round-robin picker
  - inputs: eligible mask and pointer
  - outputs: one-hot winner and valid
  - reusable by other shared-resource blocks

Test Plan:
- Pad1 cmd=1, core_armed=0, then pad1 digits 4,2,1 one per 3 cycles -> one cycle of core_command=1 with grant=4'b0010, followed by core_digit 4,2,1 each one cycle after its strobe, then RELEASE, grant=0.
- Pads 0 and 2 request arm in the same cycle, pointer 0 -> pad0 served first; after release, pad2 is granted with no idle gap beyond RELEASE and IDLE.
- Pad3 cmd=2 with core_armed=0 and core_alarm=0 -> never granted; busy stays 0.
- Session owner sends 1 digit then goes silent, TIMEOUT=8 -> timeout_flush 8 cycles after that digit, then two consecutive core_digit=4'hF strobes, then release.
- Pad2 digit during pad0's session -> no core_digit_enterd and no count change; pad0's own 3 digits still complete the session.
- Reset asserted in SESSION after 2 digits -> next cycle all outputs 0 and state IDLE; no flush digits emitted.
